// File: rtl/vga_timing_pkg.sv
// Shared constants for the 640x480@60 raster and the line-fetch state encoding.
package vga_timing_pkg;

  localparam int unsigned VGA_HACTIVE = 640;
  localparam int unsigned VGA_HFP     = 16;
  localparam int unsigned VGA_HSYNC   = 96;
  localparam int unsigned VGA_HBP     = 48;

  localparam int unsigned VGA_VACTIVE = 480;
  localparam int unsigned VGA_VFP     = 10;
  localparam int unsigned VGA_VSYNC   = 2;
  localparam int unsigned VGA_VBP     = 33;

  localparam bit VGA_HSYNC_POL = 1'b0;
  localparam bit VGA_VSYNC_POL = 1'b0;

  function automatic int unsigned span_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned VGA_HTOTAL = span_total(VGA_HACTIVE, VGA_HFP, VGA_HSYNC, VGA_HBP);
  localparam int unsigned VGA_VTOTAL = span_total(VGA_VACTIVE, VGA_VFP, VGA_VSYNC, VGA_VBP);

  typedef enum logic {
    StIdle = 1'b0,
    StPend = 1'b1
  } fetch_st_e;

endpackage

// File: rtl/raster_counter.sv
// Modulo counter 0..TERMINAL with synchronous clear; wrap flags the terminal step.
module raster_counter #(
  parameter int unsigned WIDTH    = 11,
  parameter int unsigned TERMINAL = 799
) (
  input  logic             VCLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] cnt_q;

  assign wrap = inc && !clr && (cnt_q == LAST);
  assign cnt  = cnt_q;

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with per-line fetch request and sticky underrun flag.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned HACTIVE    = VGA_HACTIVE,
  parameter int unsigned HFP        = VGA_HFP,
  parameter int unsigned HSYNC      = VGA_HSYNC,
  parameter int unsigned HBP        = VGA_HBP,
  parameter int unsigned VACTIVE    = VGA_VACTIVE,
  parameter int unsigned VFP        = VGA_VFP,
  parameter int unsigned VSYNC      = VGA_VSYNC,
  parameter int unsigned VBP        = VGA_VBP,
  parameter bit          HSYNC_POL  = VGA_HSYNC_POL,
  parameter bit          VSYNC_POL  = VGA_VSYNC_POL,
  parameter int unsigned FCNT_WIDTH = 8
) (
  input  logic                  VCLK,
  input  logic                  RST,
  input  logic                  iEN,
  input  logic                  iLINE_ACK,
  input  logic                  iUNDERRUN_CLR,
  output logic                  oHSYNC,
  output logic                  oVSYNC,
  output logic                  oDE,
  output logic [ADDR_WIDTH-1:0] oH_ADDR,
  output logic [ADDR_WIDTH-1:0] oV_ADDR,
  output logic                  oFRAME_START,
  output logic [FCNT_WIDTH-1:0] oFRAME_CNT,
  output logic                  oLINE_REQ,
  output logic [ADDR_WIDTH-1:0] oLINE_IDX,
  output logic                  oUNDERRUN
);

  localparam int unsigned HTOTAL = span_total(HACTIVE, HFP, HSYNC, HBP);
  localparam int unsigned VTOTAL = span_total(VACTIVE, VFP, VSYNC, VBP);

  localparam logic [ADDR_WIDTH-1:0] H_ACT      = ADDR_WIDTH'(HACTIVE);
  localparam logic [ADDR_WIDTH-1:0] H_SYNC_BEG = ADDR_WIDTH'(HACTIVE + HFP);
  localparam logic [ADDR_WIDTH-1:0] H_SYNC_END = ADDR_WIDTH'(HACTIVE + HFP + HSYNC);
  localparam logic [ADDR_WIDTH-1:0] V_ACT      = ADDR_WIDTH'(VACTIVE);
  localparam logic [ADDR_WIDTH-1:0] V_SYNC_BEG = ADDR_WIDTH'(VACTIVE + VFP);
  localparam logic [ADDR_WIDTH-1:0] V_SYNC_END = ADDR_WIDTH'(VACTIVE + VFP + VSYNC);
  localparam logic [ADDR_WIDTH-1:0] V_LAST     = ADDR_WIDTH'(VTOTAL - 1);

  logic [ADDR_WIDTH-1:0] h_cnt;
  logic [ADDR_WIDTH-1:0] v_cnt;
  logic                  h_wrap;
  logic                  v_wrap;

  raster_counter #(
    .WIDTH    (ADDR_WIDTH),
    .TERMINAL (HTOTAL - 1)
  ) u_h_cnt (
    .VCLK (VCLK),
    .RST  (RST),
    .inc  (iEN),
    .clr  (!iEN),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  raster_counter #(
    .WIDTH    (ADDR_WIDTH),
    .TERMINAL (VTOTAL - 1)
  ) u_v_cnt (
    .VCLK (VCLK),
    .RST  (RST),
    .inc  (h_wrap),
    .clr  (!iEN),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  logic h_act;
  logic v_act;
  logic hs_act;
  logic vs_act;

  assign h_act  = h_cnt < H_ACT;
  assign v_act  = v_cnt < V_ACT;
  assign hs_act = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign vs_act = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  logic                  hsync_q;
  logic                  vsync_q;
  logic                  de_q;
  logic [ADDR_WIDTH-1:0] h_addr_q;
  logic [ADDR_WIDTH-1:0] v_addr_q;
  logic                  frame_start_q;
  logic [FCNT_WIDTH-1:0] frame_cnt_q;

  // Outputs are a one-clock delayed decode of the counters; the frame count survives iEN=0.
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      h_addr_q      <= '0;
      v_addr_q      <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (!iEN) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      h_addr_q      <= '0;
      v_addr_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      de_q          <= h_act && v_act;
      h_addr_q      <= h_cnt;
      v_addr_q      <= v_cnt;
      frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + FCNT_WIDTH'(1);
      end
    end
  end

  fetch_st_e             fetch_st_q;
  logic [ADDR_WIDTH-1:0] line_idx_q;
  logic                  underrun_q;
  logic [ADDR_WIDTH-1:0] target;
  logic                  issue;
  logic                  deadline;
  logic                  ur_set;

  // Next line to load, wrapping from the last line of the frame back to line 0.
  assign target   = (v_cnt == V_LAST) ? '0 : v_cnt + ADDR_WIDTH'(1);
  assign issue    = iEN && (h_cnt == H_ACT) && (target < V_ACT);
  assign deadline = (h_cnt == '0) && (v_cnt == line_idx_q);
  assign ur_set   = iEN && (fetch_st_q == StPend) && !iLINE_ACK && deadline;

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      fetch_st_q <= StIdle;
      line_idx_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (ur_set) begin
        underrun_q <= 1'b1;
      end else if (iUNDERRUN_CLR) begin
        underrun_q <= 1'b0;
      end

      if (!iEN) begin
        fetch_st_q <= StIdle;
        line_idx_q <= '0;
      end else begin
        unique case (fetch_st_q)
          StIdle: begin
            if (issue) begin
              fetch_st_q <= StPend;
              line_idx_q <= target;
            end
          end
          StPend: begin
            // An ack on the deadline edge still counts as in time.
            if (iLINE_ACK || deadline) begin
              fetch_st_q <= StIdle;
            end
          end
          default: fetch_st_q <= StIdle;
        endcase
      end
    end
  end

  assign oHSYNC       = hsync_q;
  assign oVSYNC       = vsync_q;
  assign oDE          = de_q;
  assign oH_ADDR      = h_addr_q;
  assign oV_ADDR      = v_addr_q;
  assign oFRAME_START = frame_start_q;
  assign oFRAME_CNT   = frame_cnt_q;
  assign oLINE_REQ    = (fetch_st_q == StPend);
  assign oLINE_IDX    = line_idx_q;
  assign oUNDERRUN    = underrun_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full-size 640x480 instance and a 7x6 raster instance against a position model.
module tb_vga_timing_gen;

  localparam int unsigned AW_A = 11;
  localparam int unsigned AW_B = 3;
  localparam int unsigned HT_A = 800;
  localparam int unsigned VT_A = 525;
  localparam int unsigned HT_B = 7;
  localparam int unsigned VT_B = 6;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [10:0] h;
    logic [10:0] v;
    logic        fs;
    logic [7:0]  fc;
    logic        req;
    logic [10:0] idx;
    logic        ur;
  } obs_t;

  logic VCLK = 1'b0;
  always #5 VCLK = ~VCLK;

  logic rst_a, en_a, ack_a, clr_a;
  logic rst_b, en_b, ack_b, clr_b;

  logic            hs_a, vs_a, de_a, fs_a, req_a, ur_a;
  logic [AW_A-1:0] h_a, v_a, idx_a;
  logic [7:0]      fc_a;
  logic            hs_b, vs_b, de_b, fs_b, req_b, ur_b;
  logic [AW_B-1:0] h_b, v_b, idx_b;
  logic [7:0]      fc_b;

  vga_timing_gen u_dut_a (
    .VCLK          (VCLK),
    .RST           (rst_a),
    .iEN           (en_a),
    .iLINE_ACK     (ack_a),
    .iUNDERRUN_CLR (clr_a),
    .oHSYNC        (hs_a),
    .oVSYNC        (vs_a),
    .oDE           (de_a),
    .oH_ADDR       (h_a),
    .oV_ADDR       (v_a),
    .oFRAME_START  (fs_a),
    .oFRAME_CNT    (fc_a),
    .oLINE_REQ     (req_a),
    .oLINE_IDX     (idx_a),
    .oUNDERRUN     (ur_a)
  );

  vga_timing_gen #(
    .ADDR_WIDTH (AW_B),
    .HACTIVE    (4),
    .HFP        (1),
    .HSYNC      (1),
    .HBP        (1),
    .VACTIVE    (3),
    .VFP        (1),
    .VSYNC      (1),
    .VBP        (1),
    .HSYNC_POL  (1'b1),
    .VSYNC_POL  (1'b0),
    .FCNT_WIDTH (8)
  ) u_dut_b (
    .VCLK          (VCLK),
    .RST           (rst_b),
    .iEN           (en_b),
    .iLINE_ACK     (ack_b),
    .iUNDERRUN_CLR (clr_b),
    .oHSYNC        (hs_b),
    .oVSYNC        (vs_b),
    .oDE           (de_b),
    .oH_ADDR       (h_b),
    .oV_ADDR       (v_b),
    .oFRAME_START  (fs_b),
    .oFRAME_CNT    (fc_b),
    .oLINE_REQ     (req_b),
    .oLINE_IDX     (idx_b),
    .oUNDERRUN     (ur_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = '{hs: hs_a, vs: vs_a, de: de_a, h: h_a, v: v_a, fs: fs_a, fc: fc_a,
                   req: req_a, idx: idx_a, ur: ur_a};
  assign obs_b = '{hs: hs_b, vs: vs_b, de: de_b, h: 11'(h_b), v: 11'(v_b), fs: fs_b, fc: fc_b,
                   req: req_b, idx: 11'(idx_b), ur: ur_b};

  initial begin
    assert (HT_A - 1 < (1 << AW_A) && VT_A - 1 < (1 << AW_A) &&
            HT_B - 1 < (1 << AW_B) && VT_B - 1 < (1 << AW_B))
      else $fatal(1, "address width too narrow for raster totals");
  end

  // Raster configuration per instance: [0] full size, [1] 7x6.
  int unsigned ha [2] = '{640, 4};
  int unsigned hfp[2] = '{16, 1};
  int unsigned hsw[2] = '{96, 1};
  int unsigned hbp[2] = '{48, 1};
  int unsigned va [2] = '{480, 3};
  int unsigned vfp[2] = '{10, 1};
  int unsigned vsw[2] = '{2, 1};
  int unsigned vbp[2] = '{33, 1};
  bit          hpol[2] = '{1'b0, 1'b1};
  bit          vpol[2] = '{1'b0, 1'b0};

  // Model state: pos is the raster position (pixels since frame origin) the next edge displays.
  int unsigned pos  [2];
  int unsigned idx_m[2];
  int unsigned fcm  [2];
  bit          req_m[2];
  bit          ur_m [2];

  obs_t qa[$];
  obs_t qb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic model_step(input int d, input logic rst, input logic en, input logic ack,
                            input logic clr, output obs_t o);
    int unsigned ht, vt, h, v, t;
    bit run, set;
    ht  = ha[d] + hfp[d] + hsw[d] + hbp[d];
    vt  = va[d] + vfp[d] + vsw[d] + vbp[d];
    h   = 0;
    v   = 0;
    run = !rst && en;
    set = 1'b0;
    if (rst) begin
      pos[d] = 0; req_m[d] = 1'b0; idx_m[d] = 0; ur_m[d] = 1'b0; fcm[d] = 0;
    end else if (!en) begin
      pos[d] = 0; req_m[d] = 1'b0; idx_m[d] = 0;
      if (clr) ur_m[d] = 1'b0;
    end else begin
      h = pos[d] % ht;
      v = pos[d] / ht;
      if (h == ht - 1 && v == vt - 1) fcm[d]++;
      if (req_m[d]) begin
        if (ack) req_m[d] = 1'b0;
        else if (h == 0 && v == idx_m[d]) begin
          req_m[d] = 1'b0;
          set      = 1'b1;
        end
      end else begin
        t = (v + 1) % vt;
        if (h == ha[d] && t < va[d]) begin
          req_m[d] = 1'b1;
          idx_m[d] = t;
        end
      end
      if (set) ur_m[d] = 1'b1;
      else if (clr) ur_m[d] = 1'b0;
      pos[d] = (pos[d] + 1) % (ht * vt);
    end
    o.hs  = (run && h >= ha[d] + hfp[d] && h < ha[d] + hfp[d] + hsw[d]) ? hpol[d] : !hpol[d];
    o.vs  = (run && v >= va[d] + vfp[d] && v < va[d] + vfp[d] + vsw[d]) ? vpol[d] : !vpol[d];
    o.de  = run && h < ha[d] && v < va[d];
    o.h   = 11'(h);
    o.v   = 11'(v);
    o.fs  = run && h == 0 && v == 0;
    o.fc  = 8'(fcm[d]);
    o.req = req_m[d];
    o.idx = 11'(idx_m[d]);
    o.ur  = ur_m[d];
  endtask

  function automatic string fmt(input obs_t o);
    return $sformatf("h=%0d v=%0d de=%b hs=%b vs=%b fs=%b fc=%0d req=%b idx=%0d ur=%b",
                     o.h, o.v, o.de, o.hs, o.vs, o.fs, o.fc, o.req, o.idx, o.ur);
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual{%s} required{%s}", name, $time, fmt(act), fmt(exp));
    end
  endtask

  // Sample the model with the inputs the next edge will see; publish after that edge.
  task automatic tick();
    obs_t ea, eb;
    model_step(0, rst_a, en_a, ack_a, clr_a, ea);
    model_step(1, rst_b, en_b, ack_b, clr_b, eb);
    @(posedge VCLK);
    #1;
    qa.push_back(ea);
    qb.push_back(eb);
  endtask

  always @(negedge VCLK) begin
    if (qa.size() > 0) check_obs("sb_full", obs_a, qa.pop_front());
    if (qb.size() > 0) check_obs("sb_small", obs_b, qb.pop_front());
  end

  initial begin
    int unsigned age_a, age_b, dly_a, dly_b;
    obs_t er;
    age_a = 0; age_b = 0; dly_a = 0; dly_b = 1;
    rst_a = 1'b1; en_a = 1'b0; ack_a = 1'b0; clr_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; ack_b = 1'b0; clr_b = 1'b0;
    repeat (3) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int c = 0; c < 13000; c++) begin
      // Full-size raster: ack 5 clocks after each request, except the scripted lines.
      en_a = !(c >= 12000 && c < 12003);
      if (req_m[0]) age_a++;
      else age_a = 0;
      dly_a = (idx_m[0] == 11 || idx_m[0] == 14) ? 0 : ((idx_m[0] == 12) ? HT_A - 640 : 5);
      ack_a = req_m[0] && dly_a != 0 && age_a == dly_a;
      clr_a = en_a && (pos[0] == 11 * HT_A + 300 || pos[0] == 14 * HT_A);

      // Small raster: random enable drops, ack delays spanning the deadline, stray acks/clears.
      if (c == 5002) rst_b = 1'b0;
      en_b = ($urandom_range(0, 299) != 0);
      if (req_m[1]) begin
        if (age_b == 0) dly_b = $urandom_range(1, 4);
        age_b++;
      end else begin
        age_b = 0;
      end
      ack_b = req_m[1] ? (age_b == dly_b) : ($urandom_range(0, 3) == 0);
      clr_b = ($urandom_range(0, 15) == 0);

      tick();

      if (c == 5000) begin
        #2 rst_b = 1'b1;
        #1;
        model_step(1, 1'b1, 1'b0, 1'b0, 1'b0, er);
        check_obs("async_rst", obs_b, er);
        void'(qb.pop_back());
        qb.push_back(er);
      end
    end

    @(negedge VCLK);
    #1;
    checks++;
    if (qa.size() + qb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d pending required=0", qa.size() + qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
